// File: rtl/sdram_wb_arbiter_if.sv
// Wishbone signal bundle for the CPU master, DMA master and SDRAM slave port of sdram_wb_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface sdram_wb_arbiter_if;
  logic        cpu_stb_i, cpu_cyc_i, cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_adr_i, cpu_dat_i;
  logic        cpu_ack_o;
  logic [31:0] cpu_dat_o;

  logic        dma_stb_i, dma_cyc_i, dma_we_i;
  logic [3:0]  dma_sel_i;
  logic [31:0] dma_adr_i, dma_dat_i;
  logic        dma_ack_o;
  logic [31:0] dma_dat_o;

  logic        sd_stb_o, sd_cyc_o, sd_we_o;
  logic [3:0]  sd_sel_o;
  logic [31:0] sd_adr_o, sd_dat_o;
  logic        sd_ack_i;
  logic [31:0] sd_dat_i;

  modport slave (
    input  cpu_stb_i, cpu_cyc_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    output cpu_ack_o, cpu_dat_o,
    input  dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
    output dma_ack_o, dma_dat_o,
    output sd_stb_o, sd_cyc_o, sd_we_o, sd_sel_o, sd_adr_o, sd_dat_o,
    input  sd_ack_i, sd_dat_i
  );

  modport master (
    output cpu_stb_i, cpu_cyc_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    input  cpu_ack_o, cpu_dat_o,
    output dma_stb_i, dma_cyc_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
    input  dma_ack_o, dma_dat_o,
    input  sd_stb_o, sd_cyc_o, sd_we_o, sd_sel_o, sd_adr_o, sd_dat_o,
    output sd_ack_i, sd_dat_i
  );
endinterface

// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter (CPU, DMA) in front of one SDRAM slave port; alternates on
// contention and answers a stalled slave with a forced ERR_DATA ack after TIMEOUT cycles.
//
// state   | meaning
// IDLE    | no owner, sd_* held low, arbitration decided here
// GNT_CPU | CPU owns the SDRAM port
// GNT_DMA | DMA owns the SDRAM port
module sdram_wb_arbiter #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  sdram_wb_arbiter_if.slave bus,
  output logic [1:0]        grant_o,
  output logic              timeout_err_o
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_dma_q, last_dma_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grant_q, grant_d;
  logic          err_q, err_d;

  logic req_cpu, req_dma;
  logic gnt_cpu, gnt_dma;
  logic own_cyc, timeout;

  assign req_cpu = bus.cpu_cyc_i & bus.cpu_stb_i;
  assign req_dma = bus.dma_cyc_i & bus.dma_stb_i;

  // Ownership is masked by reset so nothing leaks to the bus while reset is held.
  assign gnt_cpu = wb_rst_n & (state_q == GNT_CPU);
  assign gnt_dma = wb_rst_n & (state_q == GNT_DMA);
  assign own_cyc = (state_q == GNT_CPU) ? bus.cpu_cyc_i : bus.dma_cyc_i;
  assign timeout = (gnt_cpu | gnt_dma) & own_cyc & ~bus.sd_ack_i & (cnt_q == CNT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      last_dma_q <= 1'b1;
      cnt_q      <= '0;
      grant_q    <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_cpu && req_dma) begin
          state_d = last_dma_q ? GNT_CPU : GNT_DMA;
        end else if (req_cpu) begin
          state_d = GNT_CPU;
        end else if (req_dma) begin
          state_d = GNT_DMA;
        end
      end
      GNT_CPU, GNT_DMA: begin
        if (!own_cyc || bus.sd_ack_i || timeout) begin
          state_d    = IDLE;
          cnt_d      = '0;
          last_dma_d = (state_q == GNT_DMA);
          if (timeout) begin
            err_d = 1'b1;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == GNT_DMA, state_d == GNT_CPU};
  end

  always_comb begin
    bus.sd_stb_o = 1'b0;
    bus.sd_cyc_o = 1'b0;
    bus.sd_we_o  = 1'b0;
    bus.sd_sel_o = 4'h0;
    bus.sd_adr_o = 32'h0;
    bus.sd_dat_o = 32'h0;
    if (gnt_cpu) begin
      bus.sd_stb_o = bus.cpu_stb_i;
      bus.sd_cyc_o = bus.cpu_cyc_i;
      bus.sd_we_o  = bus.cpu_we_i;
      bus.sd_sel_o = bus.cpu_sel_i;
      bus.sd_adr_o = bus.cpu_adr_i;
      bus.sd_dat_o = bus.cpu_dat_i;
    end else if (gnt_dma) begin
      bus.sd_stb_o = bus.dma_stb_i;
      bus.sd_cyc_o = bus.dma_cyc_i;
      bus.sd_we_o  = bus.dma_we_i;
      bus.sd_sel_o = bus.dma_sel_i;
      bus.sd_adr_o = bus.dma_adr_i;
      bus.sd_dat_o = bus.dma_dat_i;
    end
  end

  always_comb begin
    bus.cpu_ack_o = gnt_cpu & (bus.sd_ack_i | timeout);
    bus.dma_ack_o = gnt_dma & (bus.sd_ack_i | timeout);
    bus.cpu_dat_o = 32'h0;
    bus.dma_dat_o = 32'h0;
    if (gnt_cpu) begin
      bus.cpu_dat_o = timeout ? ERR_DATA : bus.sd_dat_i;
    end
    if (gnt_dma) begin
      bus.dma_dat_o = timeout ? ERR_DATA : bus.sd_dat_i;
    end
  end

  assign grant_o       = grant_q;
  assign timeout_err_o = err_q;

endmodule
